// File: rtl/wb_bus_wdt_pkg.sv
// ============================================================================
// Module   : wb_bus_wdt_pkg
// Brief    : Shared FSM encodings and defaults for the Wishbone bus watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_bus_wdt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    TOUT = 2'b10,
    HOLD = 2'b11
  } wdt_state_e;

  localparam logic [31:0] ERR_RDT_DEFAULT = 32'hdeaddead;
  localparam logic [7:0]  FAULT_CNT_MAX   = 8'hff;

endpackage

`default_nettype wire

// File: rtl/wdt_fault_log.sv
// ============================================================================
// Module   : wdt_fault_log
// Brief    : Sticky fault log; a logging event takes priority over a clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wdt_fault_log
  import wb_bus_wdt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        log_en,
  input  logic        clr,
  input  logic [31:0] log_adr,
  input  logic        log_we,
  output logic        fault,
  output logic [31:0] fault_adr,
  output logic        fault_we,
  output logic [7:0]  fault_cnt
);

  logic        fault_q, fault_d;
  logic [31:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;

  always_comb begin
    fault_d = fault_q;
    adr_d   = adr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    if (clr) begin
      fault_d = 1'b0;
      adr_d   = '0;
      we_d    = 1'b0;
      cnt_d   = '0;
    end
    // A clear on the same edge as a timeout still records that timeout.
    if (log_en) begin
      fault_d = 1'b1;
      adr_d   = log_adr;
      we_d    = log_we;
      if (clr)
        cnt_d = 8'd1;
      else if (cnt_q != FAULT_CNT_MAX)
        cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fault_q <= fault_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault     = fault_q;
  assign fault_adr = adr_q;
  assign fault_we  = we_q;
  assign fault_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/wb_bus_wdt.sv
// ============================================================================
// Module   : wb_bus_wdt
// Brief    : Wishbone watchdog between arbiter and decoder; forces an error
//            ack when a slave fails to respond within TIMEOUT cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_bus_wdt
  import wb_bus_wdt_pkg::*;
#(
  parameter int unsigned TIMEOUT = 127,
  parameter logic [31:0] ERR_RDT = ERR_RDT_DEFAULT
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        s_cyc,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [3:0]  s_sel,
  input  logic [31:0] s_adr,
  input  logic [31:0] s_dat,
  output logic        s_ack,
  output logic [31:0] s_rdt,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [31:0] m_adr,
  output logic [31:0] m_dat,
  input  logic        m_ack,
  input  logic [31:0] m_rdt,
  input  logic        fault_clr,
  output logic        fault_irq,
  output logic        fault,
  output logic [31:0] fault_adr,
  output logic        fault_we,
  output logic [7:0]  fault_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  wdt_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          fault_irq_q, fault_irq_d;
  logic          pass;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        // An ack in the request cycle itself is a plain pass-through.
        if (s_cyc && s_stb && !m_ack) begin
          state_d = WAIT;
          count_d = CW'(1);
        end
      end
      WAIT: begin
        if (!s_cyc || m_ack) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          state_d = TOUT;
          count_d = '0;
        end else if (count_q < CW'(TIMEOUT)) begin
          count_d = count_q + CW'(1);
        end
      end
      TOUT: state_d = HOLD;
      HOLD: if (!s_cyc) state_d = IDLE;
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    fault_irq_d = (state_d == TOUT);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      fault_irq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fault_irq_q <= fault_irq_d;
    end
  end

  assign pass  = (state_q == IDLE) || (state_q == WAIT);

  assign m_we  = s_we;
  assign m_sel = s_sel;
  assign m_adr = s_adr;
  assign m_dat = s_dat;
  assign m_cyc = pass && s_cyc;
  assign m_stb = pass && s_stb;

  assign s_ack = wb_rst_n && ((pass && m_ack) || (state_q == TOUT));
  assign s_rdt = (state_q == TOUT) ? ERR_RDT : m_rdt;

  assign fault_irq = fault_irq_q;

  wdt_fault_log u_fault_log (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .log_en    (state_q == TOUT),
    .clr       (fault_clr),
    .log_adr   (s_adr),
    .log_we    (s_we),
    .fault     (fault),
    .fault_adr (fault_adr),
    .fault_we  (fault_we),
    .fault_cnt (fault_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_wdt.sv
// ============================================================================
// Module   : tb_wb_bus_wdt
// Brief    : Directed self-checking bench for wb_bus_wdt with TIMEOUT=16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_bus_wdt;
  import wb_bus_wdt_pkg::*;

  logic        wb_clk, wb_rst_n;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic        s_ack;
  logic [31:0] s_rdt;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat;
  logic        m_ack;
  logic [31:0] m_rdt;
  logic        fault_clr, fault_irq, fault, fault_we;
  logic [31:0] fault_adr;
  logic [7:0]  fault_cnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_bus_wdt #(.TIMEOUT(16), .ERR_RDT(32'hdeaddead)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat(s_dat), .s_ack(s_ack), .s_rdt(s_rdt),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat(m_dat), .m_ack(m_ack), .m_rdt(m_rdt),
    .fault_clr(fault_clr), .fault_irq(fault_irq), .fault(fault),
    .fault_adr(fault_adr), .fault_we(fault_we), .fault_cnt(fault_cnt)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #2;
  endtask

  task automatic req(input logic [31:0] adr, input logic we);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_sel = 4'hf;
    s_adr = adr;  s_dat = ~adr;
  endtask

  task automatic drop();
    s_cyc = 1'b0; s_stb = 1'b0; m_ack = 1'b0;
  endtask

  // Full unanswered request: cycle 0 .. 16 (TOUT), one HOLD cycle, then idle.
  task automatic do_timeout(input logic [31:0] adr, input logic we, input logic clr);
    step();
    req(adr, we);
    repeat (16) step();
    fault_clr = clr;
    step();
    fault_clr = 1'b0;
    drop();
    step();
  endtask

  initial begin
    wb_rst_n = 1'b0; fault_clr = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_sel = 4'h0;
    s_adr = '0; s_dat = '0; m_ack = 1'b0; m_rdt = '0;

    // Reset state and reset-time pass-through
    #3;
    check("rst_s_ack", 32'(s_ack), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_cnt", 32'(fault_cnt), 32'd0);
    check("rst_fault_adr", fault_adr, 32'd0);
    check("rst_fault_we", 32'(fault_we), 32'd0);
    check("rst_fault_irq", 32'(fault_irq), 32'd0);
    s_cyc = 1'b1; s_stb = 1'b1; m_ack = 1'b1; m_rdt = 32'h5a5a5a5a;
    #1;
    check("rst_m_cyc", 32'(m_cyc), 32'd1);
    check("rst_m_stb", 32'(m_stb), 32'd1);
    check("rst_s_ack_gated", 32'(s_ack), 32'd0);
    check("rst_s_rdt", s_rdt, 32'h5a5a5a5a);
    step(); step();
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    drop(); m_rdt = '0;
    wb_rst_n = 1'b1;
    step();

    // Normal read, slave acks on cycle 3
    req(32'h0000_1000, 1'b0);
    #1;
    check("rd_c0_ack", 32'(s_ack), 32'd0);
    check("rd_c0_madr", m_adr, 32'h0000_1000);
    check("rd_c0_mdat", m_dat, 32'hffff_efff);
    step();
    check("rd_c1_count", 32'(dut.count_q), 32'd1);
    check("rd_c1_state", 32'(dut.state_q), 32'(WAIT));
    step(); step();
    m_ack = 1'b1; m_rdt = 32'h12345678;
    #1;
    check("rd_c3_ack", 32'(s_ack), 32'd1);
    check("rd_c3_rdt", s_rdt, 32'h12345678);
    step();
    drop();
    #1;
    check("rd_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("rd_fault", 32'(fault), 32'd0);

    // Read that never gets an ack
    step();
    req(32'h0080_0000, 1'b0);
    m_rdt = 32'h0;
    repeat (15) step();
    #1;
    check("to_c15_ack", 32'(s_ack), 32'd0);
    check("to_c15_mcyc", 32'(m_cyc), 32'd1);
    step();
    check("to_c16_ack", 32'(s_ack), 32'd1);
    check("to_c16_rdt", s_rdt, 32'hdeaddead);
    check("to_c16_irq", 32'(fault_irq), 32'd1);
    check("to_c16_mcyc", 32'(m_cyc), 32'd0);
    check("to_c16_mstb", 32'(m_stb), 32'd0);
    step();
    check("to_c17_ack", 32'(s_ack), 32'd0);
    check("to_c17_mcyc", 32'(m_cyc), 32'd0);
    check("to_c17_irq", 32'(fault_irq), 32'd0);
    check("to_fault", 32'(fault), 32'd1);
    check("to_fault_adr", fault_adr, 32'h0080_0000);
    check("to_fault_we", 32'(fault_we), 32'd0);
    check("to_fault_cnt", 32'(fault_cnt), 32'd1);
    drop();
    step();
    check("to_back_idle", 32'(dut.state_q), 32'(IDLE));

    // Write acked on the last WAIT cycle wins over the timeout
    req(32'h0000_2000, 1'b1);
    repeat (15) step();
    m_ack = 1'b1; m_rdt = 32'h0000_0011;
    #1;
    check("wr15_ack", 32'(s_ack), 32'd1);
    check("wr15_rdt", s_rdt, 32'h0000_0011);
    step();
    drop();
    #1;
    check("wr15_cnt", 32'(fault_cnt), 32'd1);
    check("wr15_state", 32'(dut.state_q), 32'(IDLE));

    // Write acked one cycle too late: forced ack, late ack ignored
    step();
    req(32'h0000_3000, 1'b1);
    repeat (16) step();
    m_ack = 1'b1;
    #1;
    check("wr16_ack", 32'(s_ack), 32'd1);
    check("wr16_rdt", s_rdt, 32'hdeaddead);
    check("wr16_mcyc", 32'(m_cyc), 32'd0);
    step();
    check("wr16_late_ack", 32'(s_ack), 32'd0);
    check("wr16_cnt", 32'(fault_cnt), 32'd2);
    check("wr16_we", 32'(fault_we), 32'd1);
    check("wr16_adr", fault_adr, 32'h0000_3000);
    drop();
    step();

    // Plain clear
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_cnt", 32'(fault_cnt), 32'd0);
    check("clr_adr", fault_adr, 32'd0);
    check("clr_we", 32'(fault_we), 32'd0);

    // Saturation across 300 timeouts, then clear coincident with the 301st
    for (int i = 0; i < 255; i++) do_timeout(32'h0080_0000 + 32'(i * 4), 1'b0, 1'b0);
    check("sat_255", 32'(fault_cnt), 32'd255);
    for (int i = 0; i < 45; i++) do_timeout(32'h0090_0000 + 32'(i * 4), 1'b0, 1'b0);
    check("sat_300", 32'(fault_cnt), 32'd255);
    check("sat_adr", fault_adr, 32'h0090_00b0);
    do_timeout(32'h0abc_0000, 1'b1, 1'b1);
    check("clrtout_cnt", 32'(fault_cnt), 32'd1);
    check("clrtout_fault", 32'(fault), 32'd1);
    check("clrtout_adr", fault_adr, 32'h0abc_0000);
    check("clrtout_we", 32'(fault_we), 32'd1);

    // Reset mid-WAIT aborts without logging
    req(32'h0000_4000, 1'b0);
    repeat (10) step();
    wb_rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(s_ack), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("mid_rst_fault", 32'(fault), 32'd0);
    check("mid_rst_cnt", 32'(fault_cnt), 32'd0);
    drop();
    step();
    wb_rst_n = 1'b1;
    step();
    req(32'h0000_4004, 1'b0);
    step(); step();
    m_ack = 1'b1; m_rdt = 32'hcafef00d;
    #1;
    check("post_rst_ack", 32'(s_ack), 32'd1);
    check("post_rst_rdt", s_rdt, 32'hcafef00d);
    step();
    drop();
    check("post_rst_fault", 32'(fault), 32'd0);
    step();

    // Combinational slave acking in cycle 0
    req(32'h0000_5000, 1'b0);
    m_ack = 1'b1; m_rdt = 32'h0badbeef;
    #1;
    check("c0_ack", 32'(s_ack), 32'd1);
    check("c0_rdt", s_rdt, 32'h0badbeef);
    step();
    check("c0_state", 32'(dut.state_q), 32'(IDLE));
    check("c0_count", 32'(dut.count_q), 32'd0);
    drop();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
